// File: rtl/pt_rf_arb_pkg.sv
// Shared types and constants for the register-file access arbiter and the
// reusable round-robin picker.
package pt_rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rf_arb_state_t;

  // Cycles from the enable strobe to valid read data/error; WAIT lasts this long.
  localparam int unsigned RF_RSP_LATENCY = 1;

  // Width of an index into n requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pt_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above the
// pointer, wrapping, wins. Reused by other bridges that share a port.
module pt_rr_arbiter
  import pt_rf_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    o_grant  = '0;
    o_idx    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      // Pointer is always < N, so one subtraction is enough to wrap.
      cand = int'(i_ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!found && i_req[cand_idx]) begin
        found             = 1'b1;
        o_grant[cand_idx] = 1'b1;
        o_idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/pt_rf_arbiter.sv
// Shares one register-file access port between N_REQ hosts: round-robin
// accept, single-cycle enable strobe, registered response back to the winner.
module pt_rf_arbiter
  import pt_rf_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [N_REQ-1:0]               i_req_valid,
  output logic [N_REQ-1:0]               o_req_ready,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   i_req_address,
  input  logic [N_REQ-1:0][DATA_W-1:0]   i_req_wr_data,
  input  logic [N_REQ-1:0]               i_req_write,
  output logic [N_REQ-1:0]               o_rsp_valid,
  input  logic [N_REQ-1:0]               i_rsp_ready,
  output logic [DATA_W-1:0]              o_rsp_rd_data,
  output logic                           o_rsp_error,
  output logic [ADDR_W-1:0]              o_rf_address,
  output logic [DATA_W-1:0]              o_rf_wr_data,
  output logic                           o_rf_write,
  output logic                           o_rf_enable,
  input  logic [DATA_W-1:0]              i_rf_rd_data,
  input  logic                           i_rf_error
);

  localparam int IDX_W = idx_w(N_REQ);

  rf_arb_state_t    state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_grant;
  logic [N_REQ-1:0] owner_onehot;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [ADDR_W-1:0] rf_address_q;
  logic [DATA_W-1:0] rf_wr_data_q;
  logic              rf_write_q;
  logic              rf_enable_q;
  logic [DATA_W-1:0] rsp_rd_data_q;
  logic              rsp_error_q;

  pt_rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (rr_ptr_q),
    .o_grant (win_grant),
    .o_idx   (win_idx)
  );

  assign rr_ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_owner_dec
      assign owner_onehot[gi] = (owner_q == IDX_W'(gi));
    end
  endgenerate

  // The only combinational output: acceptance is decided in the IDLE cycle itself.
  assign o_req_ready   = (state_q == IDLE) ? win_grant : '0;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rd_data = rsp_rd_data_q;
  assign o_rsp_error   = rsp_error_q;
  assign o_rf_address  = rf_address_q;
  assign o_rf_wr_data  = rf_wr_data_q;
  assign o_rf_write    = rf_write_q;
  assign o_rf_enable   = rf_enable_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      rsp_valid_q   <= '0;
      rf_address_q  <= '0;
      rf_wr_data_q  <= '0;
      rf_write_q    <= 1'b0;
      rf_enable_q   <= 1'b0;
      rsp_rd_data_q <= '0;
      rsp_error_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|i_req_valid) begin
            rf_address_q <= i_req_address[win_idx];
            rf_wr_data_q <= i_req_wr_data[win_idx];
            rf_write_q   <= i_req_write[win_idx];
            owner_q      <= win_idx;
            rr_ptr_q     <= rr_ptr_d;
            rf_enable_q  <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          // Command registers keep their value so the RF bus stays quiet.
          rf_enable_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          rsp_rd_data_q <= i_rf_rd_data;
          rsp_error_q   <= i_rf_error;
          rsp_valid_q   <= owner_onehot;
          state_q       <= RESP;
        end
        RESP: begin
          if (i_rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  a_req_ready_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_req_ready));
  a_rsp_valid_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_rsp_valid));
  a_enable_in_issue: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    o_rf_enable |-> (state_q == ISSUE));
  a_ptr_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    int'(rr_ptr_q) < N_REQ);

endmodule

// File: tb/tb_pt_rf_arbiter.sv
// Directed bench for pt_rf_arbiter with two requesters and a one-cycle RF model.
module tb_pt_rf_arbiter;
  localparam int N  = 2;
  localparam int AW = 7;
  localparam int DW = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0][DW-1:0] req_wdata;
  logic [N-1:0]       req_write;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic [AW-1:0]      rf_addr;
  logic [DW-1:0]      rf_wdata;
  logic               rf_write;
  logic               rf_en;
  logic [DW-1:0]      rf_rdata;
  logic               rf_err;

  int n_tests = 0;
  int n_fail  = 0;
  int en_count = 0;
  int en_snap;
  logic [DW-1:0] model_rd;
  logic          model_err;
  logic          en_prev;

  pt_rf_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_address (req_addr),
    .i_req_wr_data (req_wdata),
    .i_req_write   (req_write),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_rd_data (rsp_data),
    .o_rsp_error   (rsp_err),
    .o_rf_address  (rf_addr),
    .o_rf_wr_data  (rf_wdata),
    .o_rf_write    (rf_write),
    .o_rf_enable   (rf_en),
    .i_rf_rd_data  (rf_rdata),
    .i_rf_error    (rf_err)
  );

  always #5 clk = ~clk;

  // RF model: valid data only in the cycle after an enable, junk otherwise.
  initial begin
    rf_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    rf_err   = 1'b1;
    forever begin
      @(negedge clk);
      en_prev = rf_en;
      @(posedge clk);
      #1;
      if (en_prev) begin
        rf_rdata = model_rd;
        rf_err   = model_err;
      end else begin
        rf_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        rf_err   = ~model_err;
      end
    end
  end

  always @(negedge clk) if (rf_en === 1'b1) en_count++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = '0;
    rsp_ready = '1;
    model_rd  = '0;
    model_err = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rf_enable", rf_en, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_write", rf_write, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_error", rsp_err, 0);
    rst_n = 1'b1;

    // Single read from requester 0
    req_valid   = 2'b01;
    req_addr[0] = 7'h04;
    req_write   = 2'b00;
    model_rd    = 64'hDEAD_BEEF;
    model_err   = 1'b0;
    #1;
    check("rd_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("rd_enable_c1", rf_en, 1);
    check("rd_addr_c1", rf_addr, 7'h04);
    check("rd_write_c1", rf_write, 0);
    check("rd_ready_c1", req_ready, 0);
    tick();
    check("rd_enable_c2", rf_en, 0);
    check("rd_rsp_valid_c2", rsp_valid, 0);
    tick();
    check("rd_rsp_valid_c3", rsp_valid, 2'b01);
    check("rd_rsp_data_c3", rsp_data, 64'hDEAD_BEEF);
    check("rd_rsp_error_c3", rsp_err, 0);
    tick();
    check("rd_rsp_done", rsp_valid, 0);

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    req_addr[0] = 7'h10;
    req_addr[1] = 7'h20;
    req_valid   = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0]    exp_oh;
      logic [AW-1:0] exp_addr;
      exp_oh   = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 7'h10 : 7'h20;
      model_rd = 64'h100 + 64'(i);
      #1;
      check($sformatf("cont%0d_ready", i), req_ready, exp_oh);
      tick();
      check($sformatf("cont%0d_rf_addr", i), rf_addr, exp_addr);
      tick();
      tick();
      check($sformatf("cont%0d_rsp_valid", i), rsp_valid, exp_oh);
      check($sformatf("cont%0d_rsp_data", i), rsp_data, 64'h100 + 64'(i));
      tick();
    end
    req_valid = '0;

    // Backpressure on requester 1 with requester 0 waiting
    req_valid   = 2'b10;
    req_addr[1] = 7'h33;
    model_rd    = 64'hCAFE;
    rsp_ready   = 2'b01;
    #1;
    check("bp_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b01;
    req_addr[0] = 7'h44;
    tick();
    tick();
    en_snap = en_count;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_rsp_valid", k), rsp_valid, 2'b10);
      check($sformatf("bp%0d_rsp_data", k), rsp_data, 64'hCAFE);
      check($sformatf("bp%0d_req_ready", k), req_ready, 0);
      check($sformatf("bp%0d_enable", k), rf_en, 0);
      tick();
    end
    check("bp_no_enable", en_count, en_snap);
    check("bp_still_valid", rsp_valid, 2'b10);
    rsp_ready = 2'b11;
    model_rd  = 64'h55;
    tick();
    #1;
    check("bp_next_grant", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("bp_next_addr", rf_addr, 7'h44);
    tick();
    tick();
    check("bp_next_rsp_valid", rsp_valid, 2'b01);
    check("bp_next_rsp_data", rsp_data, 64'h55);
    tick();

    // Write with RF error from requester 1
    req_valid    = 2'b10;
    req_write    = 2'b10;
    req_addr[1]  = 7'h7F;
    req_wdata[1] = 64'h1234;
    model_rd     = 64'h0;
    model_err    = 1'b1;
    #1;
    check("wr_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    req_write = '0;
    check("wr_enable", rf_en, 1);
    check("wr_write", rf_write, 1);
    check("wr_addr", rf_addr, 7'h7F);
    check("wr_wdata", rf_wdata, 64'h1234);
    tick();
    tick();
    check("wr_rsp_valid", rsp_valid, 2'b10);
    check("wr_rsp_error", rsp_err, 1);
    tick();
    check("wr_rsp_done", rsp_valid, 0);
    model_err = 1'b0;

    // Reset during WAIT, then pointer must restart at 0
    req_valid   = 2'b01;
    req_addr[0] = 7'h05;
    model_rd    = 64'h77;
    #1;
    check("rm_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rm_enable", rf_en, 0);
    check("rm_rsp_valid", rsp_valid, 0);
    check("rm_rf_addr", rf_addr, 0);
    check("rm_rf_wdata", rf_wdata, 0);
    check("rm_rsp_error", rsp_err, 0);
    en_snap = en_count;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rm%0d_no_rsp", k), rsp_valid, 0);
    end
    check("rm_no_enable", en_count, en_snap);
    req_valid = 2'b11;
    #1;
    check("rm_ptr_zero", req_ready, 2'b01);
    req_valid = '0;
    tick();

    // Withdrawn request: req0 valid only while busy, dropped before IDLE
    req_valid   = 2'b10;
    req_addr[1] = 7'h11;
    model_rd    = 64'h99;
    #1;
    check("wd_ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b01;
    #1;
    check("wd_ready_busy", req_ready, 0);
    tick();
    tick();
    req_valid = '0;
    check("wd_rsp_valid", rsp_valid, 2'b10);
    check("wd_rsp_data", rsp_data, 64'h99);
    en_snap = en_count;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("wd%0d_ready", k), req_ready, 0);
    end
    check("wd_no_enable", en_count, en_snap);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
